d_phy_receiver: RTL and testbench

D_PHY_RECEIVER -- requirements
Module: d_phy_receiver

---
 rtl/d_phy_pkg.sv | 21 ++
 rtl/d_phy_rx_deser.sv | 83 ++++++++
 rtl/d_phy_receiver.sv | 149 ++++++++++++++
 tb/tb_d_phy_receiver.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/d_phy_pkg.sv
// Shared D-PHY definitions: HS FSM state encodings, LP line-state constants, default sync byte.
// Used by both d_phy_receiver and d_phy_driver.
package d_phy_pkg;

  localparam logic [2:0] ST_STOP      = 3'd0;
  localparam logic [2:0] ST_HS_RQST   = 3'd1;
  localparam logic [2:0] ST_BRIDGE    = 3'd2;
  localparam logic [2:0] ST_SYNC_HUNT = 3'd3;
  localparam logic [2:0] ST_DATA      = 3'd4;
  localparam logic [2:0] ST_WAIT_STOP = 3'd5;

  // Line states as {Dp,Dn}
  localparam logic [1:0] LP11 = 2'b11;
  localparam logic [1:0] LP01 = 2'b01;
  localparam logic [1:0] LP00 = 2'b00;
  localparam logic [1:0] LP10 = 2'b10;

  // HS leader pattern, LSB-first arrival order
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hB8;

endpackage

// File: rtl/d_phy_rx_deser.sv
// HS deserializer: right-shift register (new bit into MSB), bit counter, sync comparator.
// Optional sync-hunt timeout counter built only when D_PHY_RX_SYNC_TIMEOUT_EN is defined.
module d_phy_rx_deser
  import d_phy_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT,
  parameter int         SYNC_TIMEOUT = 32
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic       shift_i,
  input  logic       hunt_i,
  input  logic       bit_i,
  output logic [7:0] shift_next_o,
  output logic       sync_match_o,
  output logic       byte_done_o,
  output logic       hunt_timeout_o
);

  if (SYNC_TIMEOUT < 8) begin : g_timeout_chk
    $error("SYNC_TIMEOUT must cover at least one full sync byte");
  end

  logic [7:0] shift_q, shift_d;
  logic [2:0] bitcnt_q, bitcnt_d;

  // Loading clears the register and enters the first HS bit in the same edge
  assign shift_next_o = load_i ? {bit_i, 7'd0} : {bit_i, shift_q[7:1]};
  assign sync_match_o = hunt_i && (shift_next_o == SYNC_BYTE);
  assign byte_done_o  = (bitcnt_q == 3'd7);

  always_comb begin
    shift_d  = shift_q;
    bitcnt_d = bitcnt_q;
    if (load_i) begin
      shift_d  = shift_next_o;
      bitcnt_d = 3'd0;
    end else if (shift_i) begin
      shift_d  = shift_next_o;
      bitcnt_d = sync_match_o ? 3'd0 : bitcnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      shift_q  <= 8'd0;
      bitcnt_q <= 3'd0;
    end else begin
      shift_q  <= shift_d;
      bitcnt_q <= bitcnt_d;
    end
  end

`ifdef D_PHY_RX_SYNC_TIMEOUT_EN
  localparam int HUNT_W = $clog2(SYNC_TIMEOUT + 1);

  logic [HUNT_W-1:0] hunt_cnt_q, hunt_cnt_d;

  // Counter holds the number of HS bits seen since bridge exit, entry bit included
  always_comb begin
    hunt_cnt_d = hunt_cnt_q;
    if (load_i) begin
      hunt_cnt_d = HUNT_W'(1);
    end else if (shift_i && hunt_i) begin
      hunt_cnt_d = hunt_cnt_q + HUNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      hunt_cnt_q <= '0;
    end else begin
      hunt_cnt_q <= hunt_cnt_d;
    end
  end

  assign hunt_timeout_o = hunt_i && shift_i && (hunt_cnt_q == HUNT_W'(SYNC_TIMEOUT - 1));
`else
  assign hunt_timeout_o = 1'b0;
`endif

endmodule

// File: rtl/d_phy_receiver.sv
// D-PHY data-lane receiver: LP entry FSM, HS sync hunt and byte delivery.
// Optional sync-hunt timeout enabled by defining D_PHY_RX_SYNC_TIMEOUT_EN.
module d_phy_receiver
  import d_phy_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT,
  parameter int         SYNC_TIMEOUT = 32
) (
  input  logic       RX_DDR_clk,
  input  logic       RX_rst,
  input  logic       Dp,
  input  logic       Dn,
  output logic [7:0] RX_BYTE_HS,
  output logic       RX_VALID,
  output logic       RX_ACTIVE,
  output logic       RX_SYNC_ERR,
  output logic [2:0] D_PHY_RX_HS_STATE,
  output logic [1:0] D_PHY_RX_LP_STATE
);

  logic [1:0] lp;
  logic [2:0] state_q, state_d;
  logic [7:0] byte_q, byte_d;
  logic       valid_q, valid_d;
  logic       active_q, active_d;
  logic       err_q, err_d;
  logic [1:0] lp_q;

  logic       load, shift, hunt;
  logic [7:0] shift_next;
  logic       sync_match, byte_done, hunt_timeout;

  assign lp   = {Dp, Dn};
  assign hunt = (state_q == ST_SYNC_HUNT);

  d_phy_rx_deser #(
    .SYNC_BYTE    (SYNC_BYTE),
    .SYNC_TIMEOUT (SYNC_TIMEOUT)
  ) u_deser (
    .clk_i          (RX_DDR_clk),
    .rst_ni         (RX_rst),
    .load_i         (load),
    .shift_i        (shift),
    .hunt_i         (hunt),
    .bit_i          (Dp),
    .shift_next_o   (shift_next),
    .sync_match_o   (sync_match),
    .byte_done_o    (byte_done),
    .hunt_timeout_o (hunt_timeout)
  );

  always_comb begin
    state_d  = state_q;
    byte_d   = byte_q;
    valid_d  = 1'b0;
    active_d = active_q;
    err_d    = 1'b0;
    load     = 1'b0;
    shift    = 1'b0;
    case (state_q)
      ST_STOP: begin
        case (lp)
          LP01:    state_d = ST_HS_RQST;
          LP11:    state_d = ST_STOP;
          default: begin state_d = ST_WAIT_STOP; err_d = 1'b1; end
        endcase
      end
      ST_HS_RQST: begin
        case (lp)
          LP01:    state_d = ST_HS_RQST;
          LP00:    state_d = ST_BRIDGE;
          LP11:    state_d = ST_STOP;
          LP10:    begin state_d = ST_WAIT_STOP; err_d = 1'b1; end
          default: state_d = ST_STOP;
        endcase
      end
      ST_BRIDGE: begin
        case (lp)
          LP00:    state_d = ST_BRIDGE;
          LP11:    state_d = ST_STOP;
          default: begin state_d = ST_SYNC_HUNT; load = 1'b1; end
        endcase
      end
      ST_SYNC_HUNT: begin
        case (lp)
          LP11:    state_d = ST_STOP;
          LP00:    begin state_d = ST_WAIT_STOP; err_d = 1'b1; end
          default: begin
            shift = 1'b1;
            if (sync_match) begin
              state_d  = ST_DATA;
              active_d = 1'b1;
            end else if (hunt_timeout) begin
              state_d = ST_WAIT_STOP;
              err_d   = 1'b1;
            end
          end
        endcase
      end
      ST_DATA: begin
        // Leaving DATA on an LP state discards any partial byte
        case (lp)
          LP11:    begin state_d = ST_STOP; active_d = 1'b0; end
          LP00:    begin state_d = ST_WAIT_STOP; active_d = 1'b0; err_d = 1'b1; end
          default: begin
            shift = 1'b1;
            if (byte_done) begin
              byte_d  = shift_next;
              valid_d = 1'b1;
            end
          end
        endcase
      end
      ST_WAIT_STOP: begin
        if (lp == LP11) state_d = ST_STOP;
      end
      default: begin
        state_d  = ST_STOP;
        active_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge RX_DDR_clk) begin
    if (!RX_rst) begin
      state_q  <= ST_STOP;
      byte_q   <= 8'h00;
      valid_q  <= 1'b0;
      active_q <= 1'b0;
      err_q    <= 1'b0;
      lp_q     <= LP11;
    end else begin
      state_q  <= state_d;
      byte_q   <= byte_d;
      valid_q  <= valid_d;
      active_q <= active_d;
      err_q    <= err_d;
      lp_q     <= lp;
    end
  end

  assign RX_BYTE_HS        = byte_q;
  assign RX_VALID          = valid_q;
  assign RX_ACTIVE         = active_q;
  assign RX_SYNC_ERR       = err_q;
  assign D_PHY_RX_HS_STATE = state_q;
  assign D_PHY_RX_LP_STATE = lp_q;

endmodule

// File: tb/tb_d_phy_receiver.sv
// Directed self-checking bench for d_phy_receiver; outputs sampled 1 time unit after each rising edge.
module tb_d_phy_receiver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dp = 1'b1;
  logic       dn = 1'b1;
  logic [7:0] rx_byte;
  logic       rx_valid, rx_active, rx_err;
  logic [2:0] rx_state;
  logic [1:0] rx_lp;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;
  logic [7:0] got_q[$];
  int         got_t[$];

  always #5 clk = ~clk;

  d_phy_receiver dut (
    .RX_DDR_clk        (clk),
    .RX_rst            (rst_n),
    .Dp                (dp),
    .Dn                (dn),
    .RX_BYTE_HS        (rx_byte),
    .RX_VALID          (rx_valid),
    .RX_ACTIVE         (rx_active),
    .RX_SYNC_ERR       (rx_err),
    .D_PHY_RX_HS_STATE (rx_state),
    .D_PHY_RX_LP_STATE (rx_lp)
  );

  // Records every delivered byte with its cycle stamp
  always @(negedge clk) begin
    cyc++;
    if (rx_valid === 1'b1) begin
      got_q.push_back(rx_byte);
      got_t.push_back(cyc);
    end
  end

  task automatic step(input logic [1:0] lp);
    @(negedge clk);
    dp = lp[1];
    dn = lp[0];
    @(posedge clk);
    #1;
  endtask

  task automatic hs_bit(input logic b);
    step({b, ~b});
  endtask

  task automatic hs_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) hs_bit(b[i]);
  endtask

  task automatic enter_burst();
    step(2'b11);
    step(2'b01);
    step(2'b00);
    for (int i = 0; i < 4; i++) hs_bit(1'b0);
    hs_byte(8'hB8);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(2'b01);
    step(2'b01);
    nvec++; if (rx_state !== 3'd0) begin nerr++; $display("FAIL rst_state: got %0d want 0", rx_state); end
    nvec++; if (rx_byte !== 8'h00) begin nerr++; $display("FAIL rst_byte: got %h want 00", rx_byte); end
    nvec++; if (rx_valid !== 1'b0) begin nerr++; $display("FAIL rst_valid: got %b want 0", rx_valid); end
    nvec++; if (rx_active !== 1'b0) begin nerr++; $display("FAIL rst_active: got %b want 0", rx_active); end
    nvec++; if (rx_err !== 1'b0) begin nerr++; $display("FAIL rst_err: got %b want 0", rx_err); end
    nvec++; if (rx_lp !== 2'b11) begin nerr++; $display("FAIL rst_lp: got %b want 11", rx_lp); end
    rst_n = 1'b1;
  endtask

  task automatic test_burst();
    logic [7:0] exp_b [4] = '{8'hA5, 8'h3C, 8'hFF, 8'h11};
    got_q.delete(); got_t.delete();
    step(2'b11);
    nvec++; if (rx_state !== 3'd0 || rx_lp !== 2'b11) begin nerr++; $display("FAIL burst_stop: got st=%0d lp=%b want st=0 lp=11", rx_state, rx_lp); end
    step(2'b01);
    nvec++; if (rx_state !== 3'd1 || rx_lp !== 2'b01) begin nerr++; $display("FAIL burst_rqst: got st=%0d lp=%b want st=1 lp=01", rx_state, rx_lp); end
    step(2'b00);
    nvec++; if (rx_state !== 3'd2) begin nerr++; $display("FAIL burst_bridge: got st=%0d want 2", rx_state); end
    hs_bit(1'b0);
    nvec++; if (rx_state !== 3'd3 || rx_active !== 1'b0) begin nerr++; $display("FAIL burst_hunt: got st=%0d act=%b want st=3 act=0", rx_state, rx_active); end
    for (int i = 0; i < 3; i++) hs_bit(1'b0);
    hs_byte(8'hB8);
    nvec++; if (rx_state !== 3'd4 || rx_active !== 1'b1 || rx_valid !== 1'b0) begin nerr++; $display("FAIL burst_sync: got st=%0d act=%b vld=%b want st=4 act=1 vld=0", rx_state, rx_active, rx_valid); end
    for (int k = 0; k < 4; k++) begin
      hs_byte(exp_b[k]);
      nvec++; if (rx_valid !== 1'b1 || rx_byte !== exp_b[k] || rx_active !== 1'b1) begin nerr++; $display("FAIL burst_byte%0d: got vld=%b byte=%h act=%b want vld=1 byte=%h act=1", k, rx_valid, rx_byte, rx_active, exp_b[k]); end
    end
    step(2'b11);
    nvec++; if (rx_state !== 3'd0 || rx_active !== 1'b0 || rx_valid !== 1'b0) begin nerr++; $display("FAIL burst_end: got st=%0d act=%b vld=%b want st=0 act=0 vld=0", rx_state, rx_active, rx_valid); end
    nvec++; if (rx_byte !== 8'h11) begin nerr++; $display("FAIL burst_hold: got %h want 11", rx_byte); end
    nvec++; if (got_q.size() !== 4) begin nerr++; $display("FAIL burst_count: got %0d want 4", got_q.size()); end
    if (got_q.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        nvec++; if (got_q[k] !== exp_b[k]) begin nerr++; $display("FAIL burst_seq%0d: got %h want %h", k, got_q[k], exp_b[k]); end
        if (k > 0) begin
          nvec++; if (got_t[k] - got_t[k-1] !== 8) begin nerr++; $display("FAIL burst_gap%0d: got %0d want 8", k, got_t[k] - got_t[k-1]); end
        end
      end
    end
  endtask

  task automatic test_abort();
    got_q.delete(); got_t.delete();
    enter_burst();
    hs_byte(8'hA5); hs_byte(8'h3C); hs_byte(8'hFF); hs_byte(8'h11);
    for (int i = 0; i < 3; i++) hs_bit(1'b1);
    step(2'b11);
    nvec++; if (rx_state !== 3'd0 || rx_active !== 1'b0 || rx_valid !== 1'b0) begin nerr++; $display("FAIL abort_end: got st=%0d act=%b vld=%b want st=0 act=0 vld=0", rx_state, rx_active, rx_valid); end
    for (int i = 0; i < 3; i++) step(2'b11);
    nvec++; if (got_q.size() !== 4) begin nerr++; $display("FAIL abort_count: got %0d want 4", got_q.size()); end
  endtask

  task automatic test_illegal_lp();
    step(2'b11);
    step(2'b10);
    nvec++; if (rx_err !== 1'b1 || rx_state !== 3'd5) begin nerr++; $display("FAIL ill_stop10: got err=%b st=%0d want err=1 st=5", rx_err, rx_state); end
    step(2'b10);
    nvec++; if (rx_err !== 1'b0 || rx_state !== 3'd5) begin nerr++; $display("FAIL ill_strobe: got err=%b st=%0d want err=0 st=5", rx_err, rx_state); end
    step(2'b01);
    nvec++; if (rx_err !== 1'b0 || rx_state !== 3'd5) begin nerr++; $display("FAIL ill_wait: got err=%b st=%0d want err=0 st=5", rx_err, rx_state); end
    step(2'b11);
    nvec++; if (rx_state !== 3'd0) begin nerr++; $display("FAIL ill_recover: got st=%0d want 0", rx_state); end
    step(2'b01);
    step(2'b10);
    nvec++; if (rx_err !== 1'b1 || rx_state !== 3'd5) begin nerr++; $display("FAIL ill_rqst10: got err=%b st=%0d want err=1 st=5", rx_err, rx_state); end
    enter_burst();
    hs_byte(8'hA5);
    nvec++; if (rx_valid !== 1'b1 || rx_byte !== 8'hA5) begin nerr++; $display("FAIL ill_burst: got vld=%b byte=%h want vld=1 byte=a5", rx_valid, rx_byte); end
    step(2'b11);
  endtask

  task automatic test_timeout();
    int errs = 0;
    step(2'b11); step(2'b01); step(2'b00);
    for (int i = 1; i <= 40; i++) begin
      hs_bit(1'b0);
      if (rx_err === 1'b1) errs++;
`ifdef D_PHY_RX_SYNC_TIMEOUT_EN
      if (i == 31) begin
        nvec++; if (rx_err !== 1'b0 || rx_state !== 3'd3) begin nerr++; $display("FAIL tmo_bit31: got err=%b st=%0d want err=0 st=3", rx_err, rx_state); end
      end
      if (i == 32) begin
        nvec++; if (rx_err !== 1'b1 || rx_state !== 3'd5) begin nerr++; $display("FAIL tmo_bit32: got err=%b st=%0d want err=1 st=5", rx_err, rx_state); end
      end
`endif
    end
`ifdef D_PHY_RX_SYNC_TIMEOUT_EN
    nvec++; if (errs !== 1 || rx_state !== 3'd5) begin nerr++; $display("FAIL tmo_end: got errs=%0d st=%0d want errs=1 st=5", errs, rx_state); end
`else
    nvec++; if (errs !== 0 || rx_state !== 3'd3) begin nerr++; $display("FAIL tmo_end: got errs=%0d st=%0d want errs=0 st=3", errs, rx_state); end
`endif
    step(2'b11);
    nvec++; if (rx_state !== 3'd0) begin nerr++; $display("FAIL tmo_stop: got st=%0d want 0", rx_state); end
  endtask

  task automatic test_reset_mid();
    enter_burst();
    hs_byte(8'hA5);
    hs_bit(1'b0);
    got_q.delete(); got_t.delete();
    hs_bit(1'b0); hs_bit(1'b1); hs_bit(1'b1);
    rst_n = 1'b0;
    hs_bit(1'b1);
    nvec++; if (rx_state !== 3'd0 || rx_byte !== 8'h00 || rx_valid !== 1'b0) begin nerr++; $display("FAIL mid_rst_a: got st=%0d byte=%h vld=%b want st=0 byte=00 vld=0", rx_state, rx_byte, rx_valid); end
    nvec++; if (rx_active !== 1'b0 || rx_err !== 1'b0 || rx_lp !== 2'b11) begin nerr++; $display("FAIL mid_rst_b: got act=%b err=%b lp=%b want act=0 err=0 lp=11", rx_active, rx_err, rx_lp); end
    rst_n = 1'b1;
    hs_bit(1'b1); hs_bit(1'b0); hs_bit(1'b0);
    step(2'b11); step(2'b11);
    nvec++; if (got_q.size() !== 0) begin nerr++; $display("FAIL mid_rst_novld: got %0d strobes want 0", got_q.size()); end
    enter_burst();
    hs_byte(8'h3C);
    nvec++; if (rx_valid !== 1'b1 || rx_byte !== 8'h3C) begin nerr++; $display("FAIL mid_rst_again: got vld=%b byte=%h want vld=1 byte=3c", rx_valid, rx_byte); end
    step(2'b11);
  endtask

  task automatic test_lp00_data();
    enter_burst();
    hs_byte(8'hA5);
    hs_bit(1'b1); hs_bit(1'b0);
    step(2'b00);
    nvec++; if (rx_err !== 1'b1 || rx_active !== 1'b0 || rx_state !== 3'd5 || rx_valid !== 1'b0) begin nerr++; $display("FAIL lp00_err: got err=%b act=%b st=%0d vld=%b want err=1 act=0 st=5 vld=0", rx_err, rx_active, rx_state, rx_valid); end
    step(2'b00);
    nvec++; if (rx_err !== 1'b0 || rx_state !== 3'd5) begin nerr++; $display("FAIL lp00_strobe: got err=%b st=%0d want err=0 st=5", rx_err, rx_state); end
    step(2'b11);
    nvec++; if (rx_state !== 3'd0) begin nerr++; $display("FAIL lp00_stop: got st=%0d want 0", rx_state); end
  endtask

  initial begin
    test_reset();
    test_burst();
    test_abort();
    test_illegal_lp();
    test_timeout();
    test_reset_mid();
    test_lp00_data();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
